// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared definitions for the MEM pipeline stage.
//   mem_op_e : memory operation encodings carried on mem_op_IN
//   state_e  : two-word operation FSM states
//   SP_W     : stack pointer width
package memory_stage_pkg;

  localparam int SP_W = 32;

  typedef enum logic [2:0] {
    MEM_NONE    = 3'd0,
    MEM_LOAD    = 3'd1,
    MEM_STORE   = 3'd2,
    MEM_PUSH    = 3'd3,
    MEM_POP     = 3'd4,
    MEM_PUSH_PC = 3'd5,
    MEM_POP_PC  = 3'd6
  } mem_op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WORD2 = 1'b1
  } state_e;

endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if: bundle between the EM register, the MEM stage and the MW register.
//   *_IN  : driven by the EM side (master), consumed by the stage (slave)
//   *_OUT : driven by the stage (slave), sampled by MW / hazard logic (master)
interface memory_stage_if #(
  parameter int NUMBER_CONTROL_SIGNALS = 16
);
  logic [NUMBER_CONTROL_SIGNALS-1:0] control_signals_IN;
  logic [2:0]                        mem_op_IN;
  logic [15:0]                       alu_result_IN;
  logic [15:0]                       store_data_IN;
  logic [31:0]                       pc_IN;
  logic [3:0]                        reg_dst_num_IN;
  logic [15:0]                       reg_dst_value_IN;

  logic [NUMBER_CONTROL_SIGNALS-1:0] control_signals_OUT;
  logic [15:0]                       result_OUT;
  logic [3:0]                        reg_dst_num_OUT;
  logic [15:0]                       reg_dst_value_OUT;
  logic [31:0]                       sp_OUT;
  logic [31:0]                       pc_OUT;
  logic                              pc_load_OUT;
  logic                              stall_OUT;

  modport master (
    output control_signals_IN, mem_op_IN, alu_result_IN, store_data_IN,
           pc_IN, reg_dst_num_IN, reg_dst_value_IN,
    input  control_signals_OUT, result_OUT, reg_dst_num_OUT, reg_dst_value_OUT,
           sp_OUT, pc_OUT, pc_load_OUT, stall_OUT
  );

  modport slave (
    input  control_signals_IN, mem_op_IN, alu_result_IN, store_data_IN,
           pc_IN, reg_dst_num_IN, reg_dst_value_IN,
    output control_signals_OUT, result_OUT, reg_dst_num_OUT, reg_dst_value_OUT,
           sp_OUT, pc_OUT, pc_load_OUT, stall_OUT
  );
endinterface

// File: rtl/memory_stage_data_memory.sv
// data_memory: 16-bit word data memory, 2^ADDR_WIDTH deep.
//   i_clk            : clock
//   i_we/i_waddr/i_wdata : synchronous write port (rising edge)
//   i_raddr/o_rdata  : asynchronous read port
// Contents are deliberately not reset.
module data_memory #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_W     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the five-stage pipeline (between EM and MW).
// Owns the data memory and the 32-bit stack pointer. Executes LOAD/STORE/
// PUSH/POP of 16-bit words in one cycle and the two-word PUSH_PC/POP_PC in
// two cycles, stalling upstream during the first word.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : memory_stage_if.slave -- EM inputs in, MW-facing results out
// All outputs are combinational; the MW register supplies the pipeline delay.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int              NUMBER_CONTROL_SIGNALS = 16,
  parameter int              ADDR_WIDTH             = 11,
  parameter logic [SP_W-1:0] SP_RESET               = SP_W'(2**ADDR_WIDTH - 1)
) (
  input logic         clk,
  input logic         reset,
  memory_stage_if.slave bus
);

  localparam logic [NUMBER_CONTROL_SIGNALS-1:0] CTRL_BUBBLE = '0;

  state_e            r_state;
  logic [SP_W-1:0]   r_sp;
  logic [15:0]       r_low;
  logic              r_lat_push;

  mem_op_e           w_op;
  state_e            w_state_next;
  logic [SP_W-1:0]   w_sp_next;
  logic [SP_W-1:0]   w_sp_inc;
  logic [SP_W-1:0]   w_sp_dec;
  logic [15:0]       w_low_next;
  logic              w_lat_push_next;

  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [15:0]           w_wdata;
  logic [ADDR_WIDTH-1:0] w_raddr;
  logic [15:0]           w_rdata;

  logic [NUMBER_CONTROL_SIGNALS-1:0] w_ctrl;
  logic [15:0]                       w_result;
  logic [31:0]                       w_pc;
  logic                              w_pc_load;
  logic                              w_stall;

  assign w_op     = mem_op_e'(bus.mem_op_IN);
  assign w_sp_inc = r_sp + SP_W'(1);
  assign w_sp_dec = r_sp - SP_W'(1);

  data_memory #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_W     (16)
  ) u_data_memory (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Operation decode: memory port control, next SP/FSM, and outputs.
  always_comb begin
    w_state_next    = r_state;
    w_sp_next       = r_sp;
    w_low_next      = r_low;
    w_lat_push_next = r_lat_push;
    w_we            = 1'b0;
    w_waddr         = r_sp[ADDR_WIDTH-1:0];
    w_wdata         = bus.store_data_IN;
    // Stack reads always look one above SP (SP points at the next free slot).
    w_raddr         = w_sp_inc[ADDR_WIDTH-1:0];
    w_ctrl          = bus.control_signals_IN;
    w_result        = bus.alu_result_IN;
    w_pc            = 32'd0;
    w_pc_load       = 1'b0;
    w_stall         = 1'b0;

    if (r_state == S_IDLE) begin
      case (w_op)
        MEM_LOAD: begin
          w_raddr  = bus.alu_result_IN[ADDR_WIDTH-1:0];
          w_result = w_rdata;
        end
        MEM_STORE: begin
          w_we    = 1'b1;
          w_waddr = bus.alu_result_IN[ADDR_WIDTH-1:0];
        end
        MEM_PUSH: begin
          w_we      = 1'b1;
          w_sp_next = w_sp_dec;
        end
        MEM_POP: begin
          w_result  = w_rdata;
          w_sp_next = w_sp_inc;
        end
        MEM_PUSH_PC: begin
          // High half goes first so it ends up at the higher address.
          w_we            = 1'b1;
          w_wdata         = bus.pc_IN[31:16];
          w_sp_next       = w_sp_dec;
          w_stall         = 1'b1;
          w_ctrl          = CTRL_BUBBLE;
          w_lat_push_next = 1'b1;
          w_state_next    = S_WORD2;
        end
        MEM_POP_PC: begin
          w_low_next      = w_rdata;
          w_sp_next       = w_sp_inc;
          w_stall         = 1'b1;
          w_ctrl          = CTRL_BUBBLE;
          w_lat_push_next = 1'b0;
          w_state_next    = S_WORD2;
        end
        default: begin
        end
      endcase
    end else begin
      // Second word: mem_op_IN is ignored, upstream is held by last cycle's stall.
      w_state_next = S_IDLE;
      if (r_lat_push) begin
        w_we      = 1'b1;
        w_wdata   = bus.pc_IN[15:0];
        w_sp_next = w_sp_dec;
      end else begin
        w_pc      = {w_rdata, r_low};
        w_pc_load = 1'b1;
        w_sp_next = w_sp_inc;
      end
    end

    // Reset wins over everything: no write, bubble, and SP shows its reset value.
    if (reset) begin
      w_we      = 1'b0;
      w_ctrl    = CTRL_BUBBLE;
      w_stall   = 1'b0;
      w_pc      = 32'd0;
      w_pc_load = 1'b0;
      w_sp_next = SP_RESET;
    end
  end

  // State boundary: FSM, SP and latched halves update here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_sp       <= SP_RESET;
      r_low      <= '0;
      r_lat_push <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sp       <= w_sp_next;
      r_low      <= w_low_next;
      r_lat_push <= w_lat_push_next;
    end
  end

  assign bus.control_signals_OUT = w_ctrl;
  assign bus.result_OUT          = w_result;
  assign bus.reg_dst_num_OUT     = bus.reg_dst_num_IN;
  assign bus.reg_dst_value_OUT   = bus.reg_dst_value_IN;
  assign bus.sp_OUT              = w_sp_next;
  assign bus.pc_OUT              = w_pc;
  assign bus.pc_load_OUT         = w_pc_load;
  assign bus.stall_OUT           = w_stall;

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: scoreboard of expected per-cycle outputs fed by
// an instruction-level reference model (array memory + integer SP).
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int NCS   = 16;
  localparam int AW    = 11;
  localparam int DEPTH = 2**AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_stage_if #(.NUMBER_CONTROL_SIGNALS(NCS)) bus ();

  memory_stage #(
    .NUMBER_CONTROL_SIGNALS (NCS),
    .ADDR_WIDTH             (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    bit          rst_mode;
    bit          chk_result;
    logic [15:0] ctrl;
    logic [15:0] result;
    logic [3:0]  num;
    logic [15:0] val;
    logic [31:0] sp;
    logic [31:0] pc;
    logic        pc_load;
    logic        stall;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [15:0] m_mem [DEPTH];
  logic [31:0] m_sp;

  task automatic apply(input logic rst, input logic [2:0] op, input logic [15:0] ctrl,
                       input logic [15:0] alu, input logic [15:0] sd, input logic [31:0] pc,
                       input logic [3:0] num, input logic [15:0] val);
    reset                  = rst;
    bus.mem_op_IN          = op;
    bus.control_signals_IN = ctrl;
    bus.alu_result_IN      = alu;
    bus.store_data_IN      = sd;
    bus.pc_IN              = pc;
    bus.reg_dst_num_IN     = num;
    bus.reg_dst_value_IN   = val;
  endtask

  function automatic exp_t base(input string name, input logic [15:0] ctrl,
                                input logic [15:0] alu, input logic [3:0] num,
                                input logic [15:0] val);
    exp_t e;
    e.name       = name;
    e.rst_mode   = 1'b0;
    e.chk_result = 1'b1;
    e.ctrl       = ctrl;
    e.result     = alu;
    e.num        = num;
    e.val        = val;
    e.sp         = m_sp;
    e.pc         = 32'd0;
    e.pc_load    = 1'b0;
    e.stall      = 1'b0;
    return e;
  endfunction

  // One instruction; two-word ops occupy two cycles with inputs held.
  task automatic issue(input string name, input logic [2:0] op, input logic [15:0] ctrl,
                       input logic [15:0] alu, input logic [15:0] sd, input logic [31:0] pc,
                       input logic [3:0] num, input logic [15:0] val);
    exp_t e;
    exp_t e2;
    logic [15:0] lo;
    logic [15:0] hi;
    @(posedge clk); #1;
    apply(1'b0, op, ctrl, alu, sd, pc, num, val);
    e = base(name, ctrl, alu, num, val);
    if (op == MEM_PUSH_PC || op == MEM_POP_PC) begin
      e.stall      = 1'b1;
      e.ctrl       = '0;
      e.chk_result = 1'b0;
      if (op == MEM_PUSH_PC) begin
        m_mem[m_sp[AW-1:0]] = pc[31:16];
        m_sp = m_sp - 32'd1;
      end else begin
        m_sp = m_sp + 32'd1;
        lo   = m_mem[m_sp[AW-1:0]];
      end
      e.sp = m_sp;
      q.push_back(e);
      @(posedge clk); #1;
      e2 = base({name, "_w2"}, ctrl, alu, num, val);
      if (op == MEM_PUSH_PC) begin
        m_mem[m_sp[AW-1:0]] = pc[15:0];
        m_sp = m_sp - 32'd1;
      end else begin
        m_sp = m_sp + 32'd1;
        hi   = m_mem[m_sp[AW-1:0]];
        e2.pc      = {hi, lo};
        e2.pc_load = 1'b1;
      end
      e2.sp = m_sp;
      q.push_back(e2);
    end else begin
      case (op)
        MEM_LOAD:  e.result = m_mem[alu[AW-1:0]];
        MEM_STORE: m_mem[alu[AW-1:0]] = sd;
        MEM_PUSH: begin
          m_mem[m_sp[AW-1:0]] = sd;
          m_sp = m_sp - 32'd1;
        end
        MEM_POP: begin
          m_sp = m_sp + 32'd1;
          e.result = m_mem[m_sp[AW-1:0]];
        end
        default: begin
        end
      endcase
      e.sp = m_sp;
      q.push_back(e);
    end
  endtask

  function automatic exp_t rst_exp(input string name);
    exp_t e;
    e = base(name, '0, '0, '0, '0);
    e.rst_mode = 1'b1;
    return e;
  endfunction

  // Reset cycle with arbitrary op on the bus; the model ignores the op.
  task automatic reset_cycle(input string name, input logic [2:0] op,
                             input logic [15:0] alu, input logic [15:0] sd);
    @(posedge clk); #1;
    apply(1'b1, op, 16'hFFFF, alu, sd, 32'hDEAD_BEEF, 4'hF, 16'h1111);
    q.push_back(rst_exp(name));
    m_sp = 32'h0000_07FF;
  endtask

  // POP_PC whose second cycle is hit by reset.
  task automatic pop_pc_reset();
    exp_t e;
    @(posedge clk); #1;
    apply(1'b0, MEM_POP_PC, 16'h00C3, 16'h0000, 16'h0000, 32'h0, 4'h2, 16'h0042);
    e = base("poppc_rst_c1", '0, 16'h0000, 4'h2, 16'h0042);
    m_sp = m_sp + 32'd1;
    e.sp         = m_sp;
    e.stall      = 1'b1;
    e.chk_result = 1'b0;
    q.push_back(e);
    @(posedge clk); #1;
    reset = 1'b1;
    q.push_back(rst_exp("poppc_rst_c2"));
    m_sp = 32'h0000_07FF;
  endtask

  // Monitor: one expected entry per cycle, compared away from the rising edge.
  exp_t mon_e;
  bit   mon_ok;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      if (mon_e.rst_mode) begin
        mon_ok = (bus.control_signals_OUT === 16'h0) && (bus.stall_OUT === 1'b0) &&
                 (bus.pc_load_OUT === 1'b0);
      end else begin
        mon_ok = (bus.control_signals_OUT === mon_e.ctrl) &&
                 (bus.reg_dst_num_OUT === mon_e.num) &&
                 (bus.reg_dst_value_OUT === mon_e.val) &&
                 (bus.sp_OUT === mon_e.sp) && (bus.pc_OUT === mon_e.pc) &&
                 (bus.pc_load_OUT === mon_e.pc_load) && (bus.stall_OUT === mon_e.stall) &&
                 (!mon_e.chk_result || bus.result_OUT === mon_e.result);
      end
      n_checks++;
      if (mon_ok) n_pass++;
      else $display("FAIL %s: got ctrl=%h res=%h num=%h val=%h sp=%h pc=%h ld=%b st=%b | want ctrl=%h res=%h num=%h val=%h sp=%h pc=%h ld=%b st=%b (rst=%b)",
                    mon_e.name, bus.control_signals_OUT, bus.result_OUT, bus.reg_dst_num_OUT,
                    bus.reg_dst_value_OUT, bus.sp_OUT, bus.pc_OUT, bus.pc_load_OUT, bus.stall_OUT,
                    mon_e.ctrl, mon_e.result, mon_e.num, mon_e.val, mon_e.sp, mon_e.pc,
                    mon_e.pc_load, mon_e.stall, mon_e.rst_mode);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [15:0] sd5;
    apply(1'b1, MEM_NONE, '0, '0, '0, '0, '0, '0);
    m_sp = 32'h0000_07FF;

    reset_cycle("reset0", MEM_NONE, 16'h0, 16'h0);
    reset_cycle("reset1", MEM_NONE, 16'h0, 16'h0);
    issue("none_1234", MEM_NONE, 16'h0055, 16'h1234, 16'h0, 32'h0, 4'h3, 16'h0777);

    // Give every word a known value.
    for (int a = 0; a < DEPTH; a++)
      issue("fill", MEM_STORE, 16'($urandom), 16'(a), 16'($urandom), 32'h0, 4'h1, 16'h0);

    // A STORE held during reset must not write.
    sd5 = ~m_mem[5];
    reset_cycle("reset_store", MEM_STORE, 16'h0005, sd5);
    issue("load_after_rst_store", MEM_LOAD, 16'h0001, 16'h0005, 16'h0, 32'h0, 4'h4, 16'h0);

    issue("store_beef", MEM_STORE, 16'h0102, 16'h0010, 16'hBEEF, 32'h0, 4'h5, 16'h0A0A);
    issue("load_beef",  MEM_LOAD,  16'h0204, 16'h0010, 16'h0000, 32'h0, 4'h6, 16'h0B0B);
    issue("load_wrap",  MEM_LOAD,  16'h0408, 16'h0810, 16'h0000, 32'h0, 4'h7, 16'h0C0C);
    issue("push_aaaa",  MEM_PUSH,  16'h0810, 16'h0000, 16'hAAAA, 32'h0, 4'h8, 16'h0D0D);
    issue("pop_aaaa",   MEM_POP,   16'h1020, 16'h0000, 16'h0000, 32'h0, 4'h9, 16'h0E0E);
    issue("push_pc",    MEM_PUSH_PC, 16'h2040, 16'h0000, 16'h0, 32'h0001_0203, 4'hA, 16'h0F0F);
    issue("pop_pc",     MEM_POP_PC,  16'h4080, 16'h0000, 16'h0, 32'h0, 4'hB, 16'h1010);
    issue("load_7ff",   MEM_LOAD,  16'h0001, 16'h07FF, 16'h0, 32'h0, 4'hC, 16'h0);
    issue("load_7fe",   MEM_LOAD,  16'h0001, 16'h07FE, 16'h0, 32'h0, 4'hD, 16'h0);
    issue("reserved7",  3'd7,      16'h8001, 16'h4321, 16'h9999, 32'h0, 4'hE, 16'h2020);
    issue("load_7fd",   MEM_LOAD,  16'h0001, 16'h07FD, 16'h0, 32'h0, 4'h0, 16'h0);

    // Seed the stack word at SP+1 so the aborted POP_PC has a defined low half.
    issue("push_pre", MEM_PUSH, 16'h0, 16'h0, 16'h1357, 32'h0, 4'h0, 16'h0);
    pop_pc_reset();
    issue("idle_after_rst", MEM_NONE, 16'h0033, 16'h5678, 16'h0, 32'h0, 4'h1, 16'h0);

    for (int i = 0; i < 600; i++) begin
      op = 3'($urandom_range(0, 7));
      issue("random", op, 16'($urandom), 16'($urandom), 16'($urandom), $urandom,
            4'($urandom), 16'($urandom));
    end

    reset_cycle("reset_wrap", MEM_NONE, 16'h0, 16'h0);
    for (int i = 0; i < DEPTH; i++)
      issue("push_wrap", MEM_PUSH, 16'h0001, 16'h0, 16'h5555, 32'h0, 4'h2, 16'h0);
    issue("wrap_sp_hold", MEM_NONE, 16'h0002, 16'h0, 16'h0, 32'h0, 4'h3, 16'h0);
    issue("load_wrap_0", MEM_LOAD, 16'h0004, 16'h0000, 16'h0, 32'h0, 4'h4, 16'h0);
    issue("pop_wrap", MEM_POP, 16'h0008, 16'h0, 16'h0, 32'h0, 4'h5, 16'h0);

    @(posedge clk); #1;
    apply(1'b0, MEM_NONE, '0, '0, '0, '0, '0, '0);
    @(negedge clk); #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending entries, want 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
